// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit BCD display driver; optional leading-zero blanking via SEG7_LEAD_ZERO_BLANK_EN.
// Outputs registered: 1 cycle after digit_idx changes, 2 edges after load; no backpressure.
module seg7_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int IDX_W       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] bcd,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  err
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] disp_q, disp_d;
    logic [N_DIGITS-1:0]   dpr_q, dpr_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  err_q, err_d;

    logic       tick;
    logic       bad_code;
    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       blank_cur;
    logic       zero_above;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0:    seg_of = 7'b0111111;
            4'd1:    seg_of = 7'b0000110;
            4'd2:    seg_of = 7'b1011011;
            4'd3:    seg_of = 7'b1001111;
            4'd4:    seg_of = 7'b1100110;
            4'd5:    seg_of = 7'b1101101;
            4'd6:    seg_of = 7'b1111101;
            4'd7:    seg_of = 7'b0000111;
            4'd8:    seg_of = 7'b1111111;
            4'd9:    seg_of = 7'b1101111;
            default: seg_of = 7'b1000000;
        endcase
    endfunction

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end

        bad_code = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) bad_code = 1'b1;
        end
        disp_d = disp_q;
        dpr_d  = dpr_q;
        err_d  = err_q;
        if (load) begin
            disp_d = bcd;
            dpr_d  = dp_in;
            err_d  = bad_code;
        end

        cur_nib = '0;
        cur_dp  = 1'b0;
        an_d    = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = disp_q[4*i +: 4];
                cur_dp  = dpr_q[i];
                an_d[i] = 1'b1;
            end
        end

        // Walk down from the top digit; digit 0 is never blanked.
        blank_cur  = 1'b0;
        zero_above = 1'b1;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (disp_q[4*i +: 4] == 4'd0);
            if ((idx_q == IDX_W'(i)) && zero_above) blank_cur = 1'b1;
        end
`endif
        seg_d = blank_cur ? 7'b0000000 : seg_of(cur_nib);
        dp_d  = cur_dp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            disp_q <= '0;
            dpr_q  <= '0;
            seg_q  <= '0;
            dp_q   <= 1'b0;
            an_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            dpr_q  <= dpr_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
            err_q  <= err_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign digit_idx = idx_q;
    assign err       = err_q;
endmodule
